// File: rtl/bin_search_ctrl.sv
// Binary-search controller: drives guesses to an external EQ/GT/LT comparator
// and reports the matching value or not-found. `STEP_COUNT_EN adds a probe counter.
module bin_search_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [WIDTH-1:0]              guess,
  output logic                          guess_vld,
  input  logic                          cmp_vld,
  input  logic                          eq,
  input  logic                          gt,
  input  logic                          lt,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic                          err,
  output logic [WIDTH-1:0]              result
`ifdef STEP_COUNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0]    steps
`endif
);

  localparam int unsigned SW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_lo, r_hi, r_guess, r_result;
  logic [WIDTH-1:0] w_lo, w_hi, w_guess, w_result;
  logic             r_guess_vld, r_busy, r_done, r_found, r_err;
  logic             w_guess_vld, w_busy, w_done, w_found, w_err;
  logic             w_fin;
  logic [SW-1:0]    r_steps, w_steps;

  // Midpoint without overflow: hi >= lo always holds, so hi-lo never wraps.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] lo,
                                           input logic [WIDTH-1:0] hi);
    return lo + ((hi - lo) >> 1);
  endfunction

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_lo        = r_lo;
    w_hi        = r_hi;
    w_guess     = r_guess;
    w_result    = r_result;
    w_guess_vld = r_guess_vld;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_found     = r_found;
    w_err       = r_err;
    w_steps     = r_steps;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lo        = '0;
          w_hi        = '1;
          w_guess     = mid('0, '1);
          w_guess_vld = 1'b1;
          w_busy      = 1'b1;
          w_found     = 1'b0;
          w_err       = 1'b0;
          w_steps     = '0;
          w_state     = S_PROBE;
        end
      end
      S_PROBE: begin
        if (cmp_vld) begin
          w_steps = r_steps + SW'(1);
          if (!$onehot({eq, gt, lt})) begin
            w_err = 1'b1;
            w_fin = 1'b1;
          end else if (eq) begin
            w_found = 1'b1;
            w_fin   = 1'b1;
          end else if (gt) begin
            // Exhaustion check precedes the decrement so hi never wraps.
            if (r_guess == r_lo) begin
              w_fin = 1'b1;
            end else begin
              w_hi    = r_guess - WIDTH'(1);
              w_guess = mid(r_lo, r_guess - WIDTH'(1));
            end
          end else begin
            if (r_guess == r_hi) begin
              w_fin = 1'b1;
            end else begin
              w_lo    = r_guess + WIDTH'(1);
              w_guess = mid(r_guess + WIDTH'(1), r_hi);
            end
          end
        end
        if (w_fin) begin
          w_result    = r_guess;
          w_done      = 1'b1;
          w_busy      = 1'b0;
          w_guess_vld = 1'b0;
          w_state     = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_guess     <= '0;
      r_result    <= '0;
      r_guess_vld <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lo        <= w_lo;
      r_hi        <= w_hi;
      r_guess     <= w_guess;
      r_result    <= w_result;
      r_guess_vld <= w_guess_vld;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_found     <= w_found;
      r_err       <= w_err;
    end
  end

`ifdef STEP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_steps <= '0;
    end else begin
      r_steps <= w_steps;
    end
  end

  assign steps = r_steps;
`else
  assign r_steps = '0;
`endif

  assign guess     = r_guess;
  assign guess_vld = r_guess_vld;
  assign busy      = r_busy;
  assign done      = r_done;
  assign found     = r_found;
  assign err       = r_err;
  assign result    = r_result;

endmodule

// File: tb/tb_bin_search_ctrl.sv
// Self-checking bench for bin_search_ctrl: a reference binary-search model
// pushes expected guesses/results, a comparator model answers the DUT.
module tb_bin_search_ctrl;

  localparam int unsigned W    = 8;
  localparam int          MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] guess;
  logic         guess_vld;
  logic         cmp_vld = 1'b0;
  logic         eq = 1'b0;
  logic         gt = 1'b0;
  logic         lt = 1'b0;
  logic         busy, done, found, err;
  logic [W-1:0] result;
`ifdef STEP_COUNT_EN
  logic [$clog2(W+2)-1:0] steps;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  int exp_q[$];
  int obs_q[$];

  // Observations captured by the driver
  bit o_found, o_err, o_busy, o_gv, o_done_after, o_found_start, o_timeout;
  int o_result, o_steps;

  always #5 clk = ~clk;

  bin_search_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .guess     (guess),
    .guess_vld (guess_vld),
    .cmp_vld   (cmp_vld),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .err       (err),
    .result    (result)
`ifdef STEP_COUNT_EN
    ,
    .steps     (steps)
`endif
  );

  // Reference search; modes: 0 true compare, 1 always gt, 2 eq+gt, 3 no flags
  task automatic model(input int t, input int mode, output bit f, output bit e,
                       output int res, output int n);
    int  lo, hi, g;
    bit  is_gt;
    lo = 0; hi = MAXV; n = 0; f = 0; e = 0; res = 0;
    while (n < 40) begin
      g = lo + (hi - lo) / 2;
      exp_q.push_back(g);
      n++;
      if (mode >= 2) begin e = 1; res = g; break; end
      if (mode == 0 && g == t) begin f = 1; res = g; break; end
      is_gt = (mode == 1) ? 1'b1 : (g > t);
      if (is_gt) begin
        if (g == lo) begin res = g; break; end
        hi = g - 1;
      end else begin
        if (g == hi) begin res = g; break; end
        lo = g + 1;
      end
    end
  endtask

  // Starts a search and plays the comparator until done (bounded)
  task automatic drive(input int t, input int mode, input int stall, input bit restart);
    int g, budget, st;
    st = stall;
    o_timeout = 0;
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    budget = 0;
    do begin
      @(posedge clk); #1;
      budget++;
    end while (!busy && budget < 8);
    start = 1'b0;
    o_found_start = found;
    if (!busy) o_timeout = 1;
    budget = 0;
    while (!o_timeout && !done) begin
      if (budget > 64) begin o_timeout = 1; break; end
      if (guess_vld) begin
        g = int'(guess);
        if (st > 0) begin
          cmp_vld = 1'b0; eq = 0; gt = 0; lt = 0;
          start = restart;
          st--;
        end else begin
          start = 1'b0;
          cmp_vld = 1'b1;
          case (mode)
            0: begin eq = (g == t); gt = (g > t); lt = (g < t); end
            1: begin eq = 0; gt = 1; lt = 0; end
            2: begin eq = 1; gt = 1; lt = 0; end
            default: begin eq = 0; gt = 0; lt = 0; end
          endcase
          obs_q.push_back(g);
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    cmp_vld = 1'b0; eq = 0; gt = 0; lt = 0; start = 1'b0;
    o_found  = found;
    o_err    = err;
    o_result = int'(result);
    o_busy   = busy;
    o_gv     = guess_vld;
`ifdef STEP_COUNT_EN
    o_steps  = int'(steps);
`else
    o_steps  = 0;
`endif
    @(posedge clk); #1;
    o_done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({guess, guess_vld, busy, done, found, err, result} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {guess, guess_vld, busy, done, found, err, result});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || guess_vld !== 1'b0)
      $display("FAIL idle_no_start: busy=%b guess_vld=%b required 0/0", busy, guess_vld);
    else n_pass++;
  endtask

  // Full search against a scoreboard of expected guesses and final outputs
  task automatic test_search(input string name, input int t, input int mode,
                             input int stall, input bit restart);
    bit ef, ee;
    int er, en, e, o;
    model(t, mode, ef, ee, er, en);
    drive(t, mode, stall, restart);
    n_checks++;
    if (o_timeout) $display("FAIL %s_timeout: no done within budget", name);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL %s_probes: got %0d required %0d", name, obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_checks++;
      if (o != e) $display("FAIL %s_guess: got %0d required %0d", name, o, e);
      else n_pass++;
    end
    n_checks++;
    if (o_found !== ef || o_err !== ee || o_result != er)
      $display("FAIL %s_result: found=%b err=%b result=%0d required %b %b %0d",
               name, o_found, o_err, o_result, ef, ee, er);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0 || o_gv !== 1'b0 || o_done_after !== 1'b0 || o_found_start !== 1'b0)
      $display("FAIL %s_handshake: busy=%b gv=%b done_next=%b found_at_start=%b required 0 0 0 0",
               name, o_busy, o_gv, o_done_after, o_found_start);
    else n_pass++;
`ifdef STEP_COUNT_EN
    n_checks++;
    if (o_steps != en) $display("FAIL %s_steps: got %0d required %0d", name, o_steps, en);
    else n_pass++;
`endif
  endtask

  task automatic test_exhaust();
    test_search("force_gt", 0, 1, 0, 1'b0);
    test_search("lt_top", 300, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    test_search("eq_gt", 50, 2, 2, 1'b1);
    test_search("no_flags", 50, 3, 0, 1'b0);
    n_checks++;
    if (found !== 1'b0 || err !== 1'b1)
      $display("FAIL err_held: found=%b err=%b required 0 1", found, err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || guess_vld !== 1'b1 || guess !== W'(127))
      $display("FAIL stall_hold: busy=%b gv=%b guess=%0d required 1 1 127", busy, guess_vld, guess);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({guess, guess_vld, busy, done, found, err, result} !== '0)
      $display("FAIL reset_mid_outputs: got %h required 0",
               {guess, guess_vld, busy, done, found, err, result});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    saw_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    n_checks++;
    if (saw_done) $display("FAIL reset_mid_done: got done pulse required none");
    else n_pass++;
    test_search("after_reset", 8'h7F, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_search("b2b_a", 8'hA5, 0, 0, 1'b0);
    test_search("b2b_b", 8'h3C, 0, 1, 1'b0);
    for (int i = 0; i < 4; i++) test_search("rand", int'($urandom_range(0, MAXV)), 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_search("mid", 8'h7F, 0, 0, 1'b0);
    test_search("zero", 8'h00, 0, 0, 1'b0);
    test_search("max", 8'hFF, 0, 0, 1'b0);
    test_exhaust();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
